// File: rtl/alu_cmd_master.sv
// Host-side ALU command issuer: queues host commands, issues 10-bit packets, checks 9-bit results in order.
// Optional build macro ALU_MST_CHECK_EN compiles in expected-value storage and result comparison.
module alu_cmd_master #(
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [1:0] cmd_op,
  output logic [9:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  input  logic [8:0] res_data,
  input  logic       res_valid,
  output logic       res_ready,
  output logic       done_valid,
  output logic [8:0] done_result,
  output logic [1:0] done_op,
  output logic       done_err,
  output logic       err_unexp,
  output logic       err_timeout,
  output logic [3:0] outstanding
);

  localparam int unsigned QAW = $clog2(QDEPTH);
  localparam int unsigned OAW = $clog2(MAX_OUT);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam logic [4:0]    MAX_OUT_C = 5'(MAX_OUT);
  localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;

  // Host command queue; the reader sees the write pointer one cycle late
  logic [9:0]   q_mem [QDEPTH];
  logic [QAW:0] q_wr, q_wr_vis, q_rd;
  logic         q_full, q_empty, q_push, load, rdy_en;

  assign q_full    = (q_wr[QAW] != q_rd[QAW]) && (q_wr[QAW-1:0] == q_rd[QAW-1:0]);
  assign q_empty   = (q_wr_vis == q_rd);
  assign cmd_ready = rdy_en && !q_full;
  assign q_push    = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (q_push) q_mem[q_wr[QAW-1:0]] <= {cmd_op, cmd_b, cmd_a};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_wr     <= '0;
      q_wr_vis <= '0;
      q_rd     <= '0;
      rdy_en   <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      q_wr_vis <= q_wr;
      if (q_push) q_wr <= q_wr + 1'b1;
      if (load)   q_rd <= q_rd + 1'b1;
    end
  end

  logic hs, res_acc;
  assign hs        = pkt_valid && pkt_ready;
  assign res_ready = (outstanding != 4'd0);
  assign res_acc   = res_valid && res_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: if (!q_empty && ({1'b0, outstanding} < MAX_OUT_C)) begin
        load     = 1'b1;
        state_nx = SEND;
      end
      SEND: if (pkt_ready) begin
        if (!q_empty && (({1'b0, outstanding} + 5'd1) < MAX_OUT_C)) load = 1'b1;
        else state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pkt_valid = (state == SEND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pkt_data <= '0;
    else if (load) pkt_data <= q_mem[q_rd[QAW-1:0]];
  end

`ifdef ALU_MST_CHECK_EN
  localparam int unsigned EW = 12;
  logic [3:0] pa, pb;
  logic [8:0] exp_val;
  logic       div0;
  assign pa = pkt_data[3:0];
  assign pb = pkt_data[7:4];
  always_comb begin
    exp_val = '0;
    div0    = 1'b0;
    unique case (pkt_data[9:8])
      2'd0: exp_val = 9'(pa) + 9'(pb);
      2'd1: exp_val = 9'(pa) - 9'(pb);
      2'd2: exp_val = 9'(pa) * 9'(pb);
      default: begin
        div0 = (pb == 4'd0);
        if (!div0) exp_val = {5'd0, pa / pb};
      end
    endcase
  end
`else
  localparam int unsigned EW = 2;
`endif

  logic [EW-1:0]  ef_mem [MAX_OUT];
  logic [EW-1:0]  ef_din, ef_head;
  logic [OAW-1:0] ef_wr, ef_rd;
  logic [1:0]     head_op;
  logic           head_err;

`ifdef ALU_MST_CHECK_EN
  assign ef_din   = {div0, pkt_data[9:8], exp_val};
  assign head_op  = ef_head[10:9];
  assign head_err = !ef_head[11] && (res_data != ef_head[8:0]);
`else
  assign ef_din   = pkt_data[9:8];
  assign head_op  = ef_head;
  assign head_err = 1'b0;
`endif
  assign ef_head = ef_mem[ef_rd];

  always_ff @(posedge clk) begin
    if (hs) ef_mem[ef_wr] <= ef_din;
  end

  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ef_wr       <= '0;
      ef_rd       <= '0;
      outstanding <= '0;
      done_valid  <= 1'b0;
      done_result <= '0;
      done_op     <= '0;
      done_err    <= 1'b0;
      err_unexp   <= 1'b0;
      err_timeout <= 1'b0;
      timer       <= '0;
    end else begin
      done_valid <= res_acc;
      if (hs) ef_wr <= ef_wr + 1'b1;
      if (res_acc) begin
        ef_rd       <= ef_rd + 1'b1;
        done_result <= res_data;
        done_op     <= head_op;
        done_err    <= head_err;
      end
      case ({hs, res_acc})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
      if (res_valid && (outstanding == 4'd0)) err_unexp <= 1'b1;
      if ((outstanding == 4'd0) || res_acc) timer <= '0;
      else if (timer != TMAX)               timer <= timer + 1'b1;
      if (timer == TMAX) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_master.sv
// Scoreboard bench for alu_cmd_master: expected packets/completions are queued when driven, checked on output.
module tb_alu_cmd_master;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [1:0] cmd_op = '0;
  logic [9:0] pkt_data;
  logic       pkt_valid, pkt_ready = 1'b0;
  logic [8:0] res_data = '0;
  logic       res_valid = 1'b0, res_ready;
  logic       done_valid, done_err, err_unexp, err_timeout;
  logic [8:0] done_result;
  logic [1:0] done_op;
  logic [3:0] outstanding;

`ifdef ALU_MST_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  alu_cmd_master #(.QDEPTH(4), .MAX_OUT(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .done_valid(done_valid), .done_result(done_result), .done_op(done_op),
    .done_err(done_err), .err_unexp(err_unexp), .err_timeout(err_timeout),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int issued   = 0;
  logic [9:0]  pkt_q[$];
  logic [11:0] done_q[$];   // {err, op, result}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] alu_model(input int a, input int b, input int op);
    int r;
    case (op)
      0: r = a + b;
      1: r = (a - b) & 511;
      2: r = a * b;
      default: r = (b == 0) ? 0 : a / b;
    endcase
    return r[8:0];
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (pkt_valid && pkt_ready) begin
        issued++;
        if (pkt_q.size() == 0) check("pkt_unexpected", {22'd0, pkt_data}, 32'hFFFF_FFFF);
        else check("pkt_data", {22'd0, pkt_data}, {22'd0, pkt_q.pop_front()});
      end
      if (done_valid) begin
        if (done_q.size() == 0) check("done_unexpected", {23'd0, done_result}, 32'hFFFF_FFFF);
        else begin
          logic [11:0] e;
          e = done_q.pop_front();
          check("done_result", {23'd0, done_result}, {23'd0, e[8:0]});
          check("done_op", {30'd0, done_op}, {30'd0, e[10:9]});
          check("done_err", {31'd0, done_err}, {31'd0, e[11]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    res_valid = 1'b0;
    pkt_ready = 1'b0;
    pkt_q.delete();
    done_q.delete();
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic send_cmd(input int a, input int b, input int op);
    logic acc;
    acc = 1'b0;
    cmd_a = 4'(a); cmd_b = 4'(b); cmd_op = 2'(op);
    cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      acc = cmd_ready;
      tick();
      if (acc) break;
    end
    cmd_valid = 1'b0;
    if (!acc) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic issue(input int a, input int b, input int op);
    logic [1:0] o;
    logic [3:0] bb, aa;
    o = 2'(op); bb = 4'(b); aa = 4'(a);
    pkt_q.push_back({o, bb, aa});
    send_cmd(a, b, op);
  endtask

  task automatic expect_done(input int op, input logic [8:0] res, input bit err);
    logic [1:0] o;
    o = 2'(op);
    done_q.push_back({err & CHECK_EN, o, res});
  endtask

  task automatic send_res(input logic [8:0] d);
    logic acc;
    acc = 1'b0;
    res_data = d;
    res_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      acc = res_ready;
      tick();
      if (acc) break;
    end
    res_valid = 1'b0;
    if (!acc) check("res_accept_timeout", 0, 1);
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 200; i++) begin
      if (outstanding == 4'(n)) break;
      tick();
    end
    check("wait_outstanding", {28'd0, outstanding}, n);
  endtask

  task automatic wait_pkt_valid();
    for (int i = 0; i < 200; i++) begin
      if (pkt_valid) break;
      tick();
    end
    check("wait_pkt_valid", {31'd0, pkt_valid}, 1);
  endtask

  int ca[10], cb[10], cop[10];
  int base;

  initial begin
    // Reset state and first command latency
    apply_reset();
    check("rst_pkt_valid", {31'd0, pkt_valid}, 0);
    check("rst_pkt_data", {22'd0, pkt_data}, 0);
    check("rst_outstanding", {28'd0, outstanding}, 0);
    check("rst_done_valid", {31'd0, done_valid}, 0);
    check("rst_errs", {30'd0, err_unexp, err_timeout}, 0);
    tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    pkt_ready = 1'b1;
    issue(3, 4, 0);
    check("lat_k0", {31'd0, pkt_valid}, 0);
    tick();
    check("lat_k1", {31'd0, pkt_valid}, 0);
    tick();
    check("lat_k2_valid", {31'd0, pkt_valid}, 1);
    check("lat_k2_data", {22'd0, pkt_data}, 10'h043);
    wait_out(1);
    expect_done(0, 9'h007, 0);
    send_res(9'h007);
    tick();
    check("add_outstanding", {28'd0, outstanding}, 0);

    // Subtraction wraps mod 512; wrong result flags done_err
    issue(3, 5, 1);
    wait_out(1);
    check("sub_model", {23'd0, alu_model(3, 5, 1)}, 32'h1FE);
    expect_done(1, 9'h1FE, 0);
    send_res(9'h1FE);
    issue(3, 5, 1);
    wait_out(1);
    expect_done(1, 9'h002, 1);
    send_res(9'h002);

    // Back-pressure holds packet stable
    pkt_ready = 1'b0;
    issue(15, 15, 2);
    wait_pkt_valid();
    repeat (5) begin
      tick();
      check("hold_valid", {31'd0, pkt_valid}, 1);
      check("hold_data", {22'd0, pkt_data}, 10'h2FF);
    end
    pkt_ready = 1'b1;
    wait_out(1);
    expect_done(2, 9'd225, 0);
    send_res(alu_model(15, 15, 2));
    wait_out(0);

    // Outstanding limit of 8
    base = issued;
    for (int i = 0; i < 10; i++) begin
      ca[i] = $urandom_range(15); cb[i] = $urandom_range(15); cop[i] = $urandom_range(3);
    end
    cop[3] = 3; cb[3] = 0;
    for (int i = 0; i < 10; i++) issue(ca[i], cb[i], cop[i]);
    repeat (20) tick();
    check("lim_outstanding", {28'd0, outstanding}, 8);
    check("lim_issued", issued - base, 8);
    check("lim_pkt_valid", {31'd0, pkt_valid}, 0);
    expect_done(cop[0], alu_model(ca[0], cb[0], cop[0]), 0);
    send_res(alu_model(ca[0], cb[0], cop[0]));
    repeat (10) tick();
    check("lim_issued_after", issued - base, 9);
    check("lim_outstanding_after", {28'd0, outstanding}, 8);
    for (int i = 1; i < 10; i++) begin
      if (cop[i] == 3 && cb[i] == 0) begin
        expect_done(3, 9'h1AB, 0);
        send_res(9'h1AB);
      end else begin
        expect_done(cop[i], alu_model(ca[i], cb[i], cop[i]), 0);
        send_res(alu_model(ca[i], cb[i], cop[i]));
      end
    end
    repeat (3) tick();
    check("drain_outstanding", {28'd0, outstanding}, 0);
    check("drain_issued", issued - base, 10);
    check("drain_done_left", done_q.size(), 0);

    // Unexpected result
    apply_reset();
    tick();
    res_data = 9'h055;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    check("unexp_flag", {31'd0, err_unexp}, 1);
    tick();
    check("unexp_sticky", {31'd0, err_unexp}, 1);
    check("unexp_outstanding", {28'd0, outstanding}, 0);

    // Timeout, then reset in the middle of a send
    apply_reset();
    tick();
    pkt_ready = 1'b1;
    issue(7, 2, 0);
    wait_out(1);
    repeat (30) tick();
    check("tmo_early", {31'd0, err_timeout}, 0);
    for (int i = 0; i < 60; i++) begin
      if (err_timeout) break;
      tick();
    end
    check("tmo_flag", {31'd0, err_timeout}, 1);
    pkt_ready = 1'b0;
    issue(1, 1, 0);
    wait_pkt_valid();
    reset = 1'b0;
    #1;
    check("mid_rst_pkt_valid", {31'd0, pkt_valid}, 0);
    check("mid_rst_outstanding", {28'd0, outstanding}, 0);
    check("mid_rst_flags", {29'd0, err_timeout, err_unexp, done_valid}, 0);
    apply_reset();
    repeat (3) tick();
    check("post_rst_pkt_valid", {31'd0, pkt_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
- Host-side command issuer for the ALU datapath.
- Accepts operand/opcode commands from a host, packs them into the 10-bit packet format {op[1:0], b[3:0], a[3:0]} and drives them with a valid/ready handshake.
- Accepts the 9-bit results coming back, matches them in order against internally computed expected values, and reports per-command completion and errors.

Parameters:
- QDEPTH, 4: host command queue entries (power of 2).
- MAX_OUT, 8: maximum issued-but-unanswered commands (power of 2, ≤15).
- TIMEOUT, 64: cycles without a result while commands are outstanding before flagging a timeout.

Ports:
- clk  in  1  clock, all flops rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  queue not full
- cmd_a  in  4  operand a (packet bits 3:0)
- cmd_b  in  4  operand b (packet bits 7:4)
- cmd_op  in  2  0 add, 1 sub, 2 mul, 3 div
- pkt_data  out  10  packed command
- pkt_valid  out  1  packet valid
- pkt_ready  in  1  downstream accepts packet
- res_data  in  9  returned result
- res_valid  in  1  result valid
- res_ready  out  1  result accepted
- done_valid  out  1  one-cycle completion pulse
- done_result  out  9  result for the completed command
- done_op  out  2  opcode of the completed command
- done_err  out  1  result mismatch, valid with done_valid
- err_unexp  out  1  sticky: result arrived with nothing outstanding
- err_timeout  out  1  sticky: TIMEOUT expired
- outstanding  out  4  count of issued, unanswered commands

Behaviour:
- Reset (reset==0, asynchronous):
  - pkt_valid=0, pkt_data=0.
  - done_valid=0, done_result=0, done_op=0, done_err=0.
  - err_unexp=0, err_timeout=0, outstanding=0.
  - Queue, expected FIFO and timer are cleared.
  - cmd_ready=1 one cycle after reset deasserts.
  - Reset mid-transfer drops all in-flight state; no done pulse is generated for lost commands.
- Command queue:
  - Write on cmd_valid&&cmd_ready.
  - cmd_ready = !queue_full.
  - Pointers wrap at QDEPTH.
- Issue FSM, states IDLE and SEND:
  - IDLE: pkt_valid=0. If the queue is non-empty and outstanding<MAX_OUT, load pkt_data from the queue head, pop the queue, go to SEND.
  - SEND: pkt_valid=1, pkt_data held stable until handshake.
  - On pkt_ready: outstanding+1 and push the expected entry.
  - After the handshake, if the queue is non-empty and outstanding+1<MAX_OUT, load the next entry and stay in SEND (back-to-back, 1 packet/cycle). Otherwise go to IDLE.
  - pkt_valid never drops without a handshake.
- Latency: a command accepted at edge k gives pkt_valid high after edge k+2 when idle.
- Expected value, 9-bit:
  - add: zero-extended a+b.
  - sub: (a-b) mod 512, e.g. 3-5 = 9'h1FE.
  - mul: a*b.
  - div: a/b truncated.
  - div with b==0: compare suppressed, done_err=0.
- Result path:
  - res_ready = (outstanding!=0).
  - Accept on res_valid&&res_ready at edge k.
  - After edge k: done_valid=1 for one cycle, done_result=res_data, done_op = op of the popped expected entry, done_err = (res_data!=expected).
- Unexpected result: res_valid while outstanding==0 sets err_unexp. The result is ignored.
- Simultaneous issue and result accept: outstanding unchanged, expected FIFO push and pop occur in the same cycle.
- Timer:
  - Counts while outstanding!=0 and no result is accepted.
  - Clears on result accept or when outstanding==0.
  - Reaching TIMEOUT sets err_timeout; the timer stops.
- Sticky error flags clear only on reset.

Optional Feature:
ALU_MST_CHECK_EN:
- Defined: expected FIFO (MAX_OUT entries of 9-bit value + op + div0 bit) and the comparator are compiled in; done_err behaves as above.
- Undefined: no expected values are stored or compared. A MAX_OUT-entry op-only FIFO provides done_op. done_err is tied to 0. All other behaviour is identical.

Test Plan:
- Reset release, cmd a=3 b=4 op=0, pkt_ready=1 → pkt_data=10'h043 two cycles after accept; result 9'h007 returned → done_valid pulse, done_result=7, done_err=0, outstanding back to 0.
- sub a=3 b=5 with a returned result of 9'h1FE → done_err=0; a returned result of 9'h002 → done_err=1.
- pkt_ready low for 5 cycles on a mul a=15 b=15 → pkt_valid and pkt_data 10'h2FF held stable; accepted on ready; result 225 → done_err=0.
- Ten commands queued, results withheld → exactly 8 packets issued, outstanding=8, no further pkt_valid; one result returned → one more issue.
- res_valid=1 after reset with nothing issued → err_unexp=1, no done_valid.
- One outstanding command with no result for 64 cycles → err_timeout=1; reset=0 mid-SEND → pkt_valid=0 immediately, all flags and outstanding cleared.
